// File: rtl/inequality_pkg.sv
// -----------------------------------------------------------------------------
// inequality_pkg
// Shared constants for the inequality block:
//   GT / EQ / LT        : bit positions of the one-hot compare result on OUT
//   DEFAULT_WIDTH       : default operand / threshold width
//   DEFAULT_THRESH_RST  : default threshold register value after reset
// -----------------------------------------------------------------------------
package inequality_pkg;

  localparam logic [1:0] GT = 2'd2;
  localparam logic [1:0] EQ = 2'd1;
  localparam logic [1:0] LT = 2'd0;

  localparam int DEFAULT_WIDTH      = 4;
  localparam int DEFAULT_THRESH_RST = 5;

endpackage

// File: rtl/inequality_cmp.sv
// -----------------------------------------------------------------------------
// inequality_cmp
// Purely combinational three-way compare of a against b.
// Ports:
//   a   [WIDTH-1:0] : operand under comparison
//   b   [WIDTH-1:0] : reference (threshold)
//   res [2:0]       : one-hot result, res[GT]=a>b, res[EQ]=a==b, res[LT]=a<b
// Configuration macro: INEQUALITY_SIGNED_EN
//   defined   -> a and b compare as two's-complement signed values
//   undefined -> a and b compare as unsigned values
// -----------------------------------------------------------------------------
module inequality_cmp
  import inequality_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       res
);

  logic a_gt_b;
  logic a_lt_b;

  always_comb begin
`ifdef INEQUALITY_SIGNED_EN
    a_gt_b = $signed(a) > $signed(b);
    a_lt_b = $signed(a) < $signed(b);
`else
    a_gt_b = a > b;
    a_lt_b = a < b;
`endif
  end

  // Priority chain guarantees exactly one bit set for any input pair.
  always_comb begin
    res = 3'b000;
    if (a_gt_b)      res[GT] = 1'b1;
    else if (a_lt_b) res[LT] = 1'b1;
    else             res[EQ] = 1'b1;
  end

endmodule

// File: rtl/inequality.sv
// -----------------------------------------------------------------------------
// inequality
// Registered three-way compare of NUM against a loadable threshold register.
// Ports:
//   clk            : clock, all state updates on rising edge
//   rst_n          : asynchronous active-low reset
//   NUM    [W-1:0] : operand under comparison
//   THR_LOAD       : load strobe for the threshold register
//   THR_IN [W-1:0] : new threshold value
//   OUT    [2:0]   : registered one-hot result {NUM>thr, NUM==thr, NUM<thr}
//   CHG            : one-cycle pulse after any edge that changed OUT
// Configuration macro: INEQUALITY_SIGNED_EN (signed compare, see inequality_cmp)
// -----------------------------------------------------------------------------
module inequality
  import inequality_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int THRESH_RST = DEFAULT_THRESH_RST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] NUM,
  input  logic             THR_LOAD,
  input  logic [WIDTH-1:0] THR_IN,
  output logic [2:0]       OUT,
  output logic             CHG
);

  localparam logic [WIDTH-1:0] THR_INIT = WIDTH'(THRESH_RST);

  logic [WIDTH-1:0] thr;
  logic [2:0]       cmp_res;

  inequality_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a   (NUM),
    .b   (thr),
    .res (cmp_res)
  );

  // The compare on a load edge sees the old thr because thr only updates at
  // that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr <= THR_INIT;
    end else if (THR_LOAD) begin
      thr <= THR_IN;
    end
  end

  // OUT==000 only exists in reset, so the first result after release is not
  // counted as a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OUT <= 3'b000;
      CHG <= 1'b0;
    end else begin
      OUT <= cmp_res;
      CHG <= (OUT != 3'b000) && (cmp_res != OUT);
    end
  end

endmodule

// File: tb/tb_inequality.sv
// -----------------------------------------------------------------------------
// tb_inequality
// Self-checking bench for inequality: directed sequence plus randomized
// traffic, checked every cycle against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_inequality;

  localparam int W   = 4;
  localparam int THR = 5;

  // clock / reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut
  logic [W-1:0] NUM;
  logic         THR_LOAD;
  logic [W-1:0] THR_IN;
  logic [2:0]   OUT;
  logic         CHG;

  inequality #(
    .WIDTH      (W),
    .THRESH_RST (THR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .NUM      (NUM),
    .THR_LOAD (THR_LOAD),
    .THR_IN   (THR_IN),
    .OUT      (OUT),
    .CHG      (CHG)
  );

  // counters
  int checks = 0;
  int passes = 0;

  function automatic void check(input string name, input logic [3:0] act,
                                input logic [3:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endfunction

  // reference model
  function automatic int to_val(input logic [W-1:0] v);
`ifdef INEQUALITY_SIGNED_EN
    return (int'(v) >= (1 << (W - 1))) ? int'(v) - (1 << W) : int'(v);
`else
    return int'(v);
`endif
  endfunction

  function automatic logic [2:0] expect_out(input logic [W-1:0] n,
                                            input logic [W-1:0] t);
    int nv;
    int tv;
    nv = to_val(n);
    tv = to_val(t);
    if (nv > tv)      return 3'b100;
    else if (nv < tv) return 3'b001;
    else              return 3'b010;
  endfunction

  logic [W-1:0] thr_m;
  logic [2:0]   prev_m;
  logic [3:0]   exp_q[$];   // {chg, out} expected after each edge

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_m  = W'(THR);
      prev_m = 3'b000;
      exp_q.delete();
    end else begin
      logic [2:0] o;
      o = expect_out(NUM, thr_m);
      exp_q.push_back({(prev_m != 3'b000) && (prev_m != o), o});
      prev_m = o;
      if (THR_LOAD) thr_m = THR_IN;
    end
  end

  // scoreboard: compare on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_out", {1'b0, OUT}, 4'b0000);
      check("reset_chg", {3'b000, CHG}, 4'b0000);
    end else if (exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      check("model_out", {1'b0, OUT}, {1'b0, e[2:0]});
      check("model_chg", {3'b000, CHG}, {3'b000, e[3]});
      check("onehot", {3'b000, $onehot(OUT)}, 4'b0001);
    end
  end

  // driver
  task automatic cycle(input logic [W-1:0] n, input logic ld,
                       input logic [W-1:0] ti);
    @(negedge clk);
    NUM      = n;
    THR_LOAD = ld;
    THR_IN   = ti;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input logic [2:0] o,
                            input logic c);
    check({name, "_out"}, {1'b0, OUT}, {1'b0, o});
    check({name, "_chg"}, {3'b000, CHG}, {3'b000, c});
  endtask

  initial begin
    rst_n    = 1'b0;
    NUM      = '0;
    THR_LOAD = 1'b0;
    THR_IN   = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_now("in_reset", 3'b000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // default thr=5, NUM=4
    cycle(4'd4, 1'b0, 4'd0);  expect_now("first_lt", 3'b001, 1'b0);
    cycle(4'd5, 1'b0, 4'd0);  expect_now("eq5", 3'b010, 1'b1);
    cycle(4'd9, 1'b0, 4'd0);
`ifdef INEQUALITY_SIGNED_EN
    expect_now("num9", 3'b001, 1'b1);   // 9 reads as -7
`else
    expect_now("num9", 3'b100, 1'b1);
`endif
    cycle(4'd4, 1'b0, 4'd0);
`ifdef INEQUALITY_SIGNED_EN
    expect_now("back4", 3'b001, 1'b0);
`else
    expect_now("back4", 3'b001, 1'b1);
`endif

    // load edge still compares against old thr
    cycle(4'd4, 1'b1, 4'd2);  expect_now("load_edge", 3'b001, 1'b0);
    cycle(4'd4, 1'b0, 4'd0);  expect_now("after_load", 3'b100, 1'b1);

    // steady input: no change pulses
    for (int i = 0; i < 10; i++) begin
      cycle(4'd4, 1'b0, 4'd0);
      expect_now("steady", 3'b100, 1'b0);
    end

    // boundaries
    cycle(4'd0, 1'b1, 4'd0);  expect_now("zero_lt2", 3'b001, 1'b1);
    cycle(4'd0, 1'b0, 4'd0);  expect_now("zero_eq0", 3'b010, 1'b1);
    cycle(4'd15, 1'b1, 4'd15);
`ifdef INEQUALITY_SIGNED_EN
    expect_now("ones_vs0", 3'b001, 1'b1);
`else
    expect_now("ones_vs0", 3'b100, 1'b1);
`endif
    cycle(4'd15, 1'b0, 4'd0); expect_now("ones_eq", 3'b010, 1'b1);

    // asynchronous reset mid-cycle, with a load pending that must be dropped
    @(negedge clk);
    NUM = 4'd5; THR_LOAD = 1'b1; THR_IN = 4'd9;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_now("async_rst", 3'b000, 1'b0);
    @(negedge clk);
    THR_LOAD = 1'b0;
    #1;
    rst_n = 1'b1;
    cycle(4'd5, 1'b0, 4'd0);  expect_now("rst_thr5", 3'b010, 1'b0);
    cycle(4'd12, 1'b0, 4'd0);
`ifdef INEQUALITY_SIGNED_EN
    expect_now("neg4", 3'b001, 1'b1);
`else
    expect_now("num12", 3'b100, 1'b1);
`endif

    // randomized traffic, checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      cycle(W'($urandom_range(0, (1 << W) - 1)),
            ($urandom_range(0, 3) == 0),
            W'($urandom_range(0, (1 << W) - 1)));
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
